apb_thr_hyst_unit: RTL



---
 rtl/apb_thr_hyst_unit.sv | 306 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/apb_thr_hyst_unit.sv
// ---------------------------------------------------------------------------
// apb_thr_hyst_unit
//
// Per-channel threshold monitor for one AFE sample stream, configured over
// APB. Each channel compares its samples against HI/LO thresholds in a
// selectable mode. Debounce requires N consecutive triggering samples, and
// release uses hysteresis. On a fire the unit sets a sticky STATUS bit and
// emits a one-cycle pulse on a routable event line.
//
// Ports:
//   clk_i, rstn_i       clock, asynchronous active-low reset
//   apb_sel_i/en_i      APB select/enable; an access needs both high
//   apb_write_i         1 = write
//   apb_address_i       byte address; bits [1:0] ignored
//   apb_wdata_i         write data
//   apb_rdata_o         combinational read data, 0 when not reading
//   apb_ready_o         constant 1 (zero wait states)
//   apb_slverr_o        error on an unmapped access
//   afe_data_vld_i      sample valid
//   afe_data_i          channel ID field plus signed sample in [W_DATA-1:0]
//   thr_events_o        one-cycle event pulses
//   irq_o               level interrupt, |(STATUS & IRQ_EN)
// ---------------------------------------------------------------------------
module apb_thr_hyst_unit #(
    parameter int W_APB_ADDR  = 12,
    parameter int NUM_CH      = 8,
    parameter int W_DATA      = 16,
    parameter int CH_ID_LSB   = 28,
    parameter int CH_ID_WIDTH = 4,
    parameter int W_CNT       = 4,
    parameter int NUM_EVT     = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  apb_sel_i,
    input  logic                  apb_en_i,
    input  logic                  apb_write_i,
    output logic                  apb_ready_o,
    output logic                  apb_slverr_o,
    input  logic [W_APB_ADDR-1:0] apb_address_i,
    input  logic [31:0]           apb_wdata_i,
    output logic [31:0]           apb_rdata_o,
    input  logic                  afe_data_vld_i,
    input  logic [31:0]           afe_data_i,
    output logic [NUM_EVT-1:0]    thr_events_o,
    output logic                  irq_o
);

    // Two guard bits keep HI-HYST and LO+HYST exact, so they cannot wrap.
    localparam int WX = W_DATA + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACTIVE = 2'd2
    } chState_e;

    logic                  ctrlEn_q, ctrlEn_d;
    logic [NUM_CH-1:0]     status_q, status_d;
    logic [NUM_CH-1:0]     irqEn_q, irqEn_d;
    logic [1:0]            mode_q   [NUM_CH];
    logic [1:0]            mode_d   [NUM_CH];
    logic [W_CNT-1:0]      debN_q   [NUM_CH];
    logic [W_CNT-1:0]      debN_d   [NUM_CH];
    logic [3:0]            evtIdx_q [NUM_CH];
    logic [3:0]            evtIdx_d [NUM_CH];
    logic [W_DATA-1:0]     thrHi_q  [NUM_CH];
    logic [W_DATA-1:0]     thrHi_d  [NUM_CH];
    logic [W_DATA-1:0]     thrLo_q  [NUM_CH];
    logic [W_DATA-1:0]     thrLo_d  [NUM_CH];
    logic [W_DATA-1:0]     hyst_q   [NUM_CH];
    logic [W_DATA-1:0]     hyst_d   [NUM_CH];
    chState_e              state_q  [NUM_CH];
    chState_e              state_d  [NUM_CH];
    logic [W_CNT-1:0]      cnt_q    [NUM_CH];
    logic [W_CNT-1:0]      cnt_d    [NUM_CH];
    logic [NUM_EVT-1:0]    events_q, events_d;

    logic                  access, wrAccess, rdAccess;
    logic                  lowRegion, chRegion, chValid, addrOk;
    logic                  regCtrl, regStatus, regIrqEn;
    logic [3:0]            addrCh;
    logic [1:0]            addrReg;
    logic [CH_ID_WIDTH-1:0] sampleCh;
    logic signed [WX-1:0]  sampleX;
    logic [NUM_CH-1:0]     trig, rel, fireMask, w1cMask;
    logic                  unusedBits;

    // Address decode: 0x000-0x00B are the global registers, and 0x100-0x1FF
    // is the per-channel window with 16 bytes per channel.
    assign access    = apb_sel_i & apb_en_i;
    assign wrAccess  = access & apb_write_i;
    assign rdAccess  = access & ~apb_write_i;
    assign addrCh    = apb_address_i[7:4];
    assign addrReg   = apb_address_i[3:2];
    assign lowRegion = (apb_address_i[W_APB_ADDR-1:4] == '0);
    assign chRegion  = (apb_address_i[W_APB_ADDR-1:8] == (W_APB_ADDR-8)'(1));
    assign regCtrl   = lowRegion & (addrReg == 2'd0);
    assign regStatus = lowRegion & (addrReg == 2'd1);
    assign regIrqEn  = lowRegion & (addrReg == 2'd2);
    assign chValid   = chRegion & (32'(addrCh) < NUM_CH);
    assign addrOk    = regCtrl | regStatus | regIrqEn | chValid;

    assign apb_ready_o  = 1'b1;
    assign apb_slverr_o = access & ~addrOk;
    assign irq_o        = |(status_q & irqEn_q);
    assign thr_events_o = events_q;

    assign sampleCh = afe_data_i[CH_ID_LSB +: CH_ID_WIDTH];
    assign sampleX  = {{2{afe_data_i[W_DATA-1]}}, afe_data_i[W_DATA-1:0]};

    assign unusedBits = ^{apb_wdata_i, afe_data_i, apb_address_i[1:0]};

    // Read mux. Register fields are zero-extended, and the CFG word also
    // carries the live FSM state in its top two bits.
    always_comb begin
        apb_rdata_o = '0;
        if (rdAccess && addrOk) begin
            if (regCtrl)   apb_rdata_o[0] = ctrlEn_q;
            if (regStatus) apb_rdata_o[NUM_CH-1:0] = status_q;
            if (regIrqEn)  apb_rdata_o[NUM_CH-1:0] = irqEn_q;
            for (int c = 0; c < NUM_CH; c++) begin
                if (chValid && (32'(addrCh) == c)) begin
                    case (addrReg)
                        2'd0: begin
                            apb_rdata_o[1:0]        = mode_q[c];
                            apb_rdata_o[4 +: W_CNT] = debN_q[c];
                            apb_rdata_o[15:12]      = evtIdx_q[c];
                            apb_rdata_o[31:30]      = state_q[c];
                        end
                        2'd1:    apb_rdata_o[W_DATA-1:0] = thrHi_q[c];
                        2'd2:    apb_rdata_o[W_DATA-1:0] = thrLo_q[c];
                        default: apb_rdata_o[W_DATA-1:0] = hyst_q[c];
                    endcase
                end
            end
        end
    end

    // Per-channel trigger and release conditions for the current sample.
    // HYST is unsigned, so it is zero-extended into the wide signed domain.
    always_comb begin
        logic signed [WX-1:0] hiX, loX, hystX;
        logic aboveHi, belowLo, relAbove, relBelow;
        hiX = '0; loX = '0; hystX = '0;
        aboveHi = 1'b0; belowLo = 1'b0; relAbove = 1'b0; relBelow = 1'b0;
        trig = '0;
        rel  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            hiX      = {{2{thrHi_q[c][W_DATA-1]}}, thrHi_q[c]};
            loX      = {{2{thrLo_q[c][W_DATA-1]}}, thrLo_q[c]};
            hystX    = {2'b00, hyst_q[c]};
            aboveHi  = sampleX > hiX;
            belowLo  = sampleX < loX;
            relAbove = sampleX <= (hiX - hystX);
            relBelow = sampleX >= (loX + hystX);
            case (mode_q[c])
                2'd1:    begin trig[c] = aboveHi;           rel[c] = relAbove;            end
                2'd2:    begin trig[c] = belowLo;           rel[c] = relBelow;            end
                2'd3:    begin trig[c] = aboveHi | belowLo; rel[c] = relAbove & relBelow; end
                default: begin trig[c] = 1'b0;              rel[c] = 1'b0;                end
            endcase
        end
    end

    // Next-state logic. The channel FSMs run first. APB writes are applied
    // afterwards so that a CFG write or a disable overrides the FSM move.
    // STATUS applies the W1C clear before OR-ing in fires, so a fire in the
    // same cycle as the clear keeps its bit set.
    always_comb begin
        logic [W_CNT-1:0] neff;
        logic [W_CNT:0]   cntInc;
        logic             accepted;
        neff     = '0;
        cntInc   = '0;
        accepted = 1'b0;
        ctrlEn_d = ctrlEn_q;
        irqEn_d  = irqEn_q;
        events_d = '0;
        fireMask = '0;
        w1cMask  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mode_d[c]   = mode_q[c];
            debN_d[c]   = debN_q[c];
            evtIdx_d[c] = evtIdx_q[c];
            thrHi_d[c]  = thrHi_q[c];
            thrLo_d[c]  = thrLo_q[c];
            hyst_d[c]   = hyst_q[c];
            state_d[c]  = state_q[c];
            cnt_d[c]    = cnt_q[c];
        end

        for (int c = 0; c < NUM_CH; c++) begin
            accepted = afe_data_vld_i & ctrlEn_q & (32'(sampleCh) == c) & (mode_q[c] != 2'd0);
            neff     = (debN_q[c] == '0) ? W_CNT'(1) : debN_q[c];
            cntInc   = {1'b0, cnt_q[c]} + (W_CNT+1)'(1);
            if (accepted) begin
                case (state_q[c])
                    IDLE: begin
                        if (trig[c]) begin
                            if (neff == W_CNT'(1)) begin
                                state_d[c]  = ACTIVE;
                                fireMask[c] = 1'b1;
                            end else begin
                                state_d[c] = PEND;
                                cnt_d[c]   = W_CNT'(1);
                            end
                        end
                    end
                    PEND: begin
                        if (!trig[c]) begin
                            state_d[c] = IDLE;
                            cnt_d[c]   = '0;
                        end else if (cntInc == {1'b0, neff}) begin
                            state_d[c]  = ACTIVE;
                            cnt_d[c]    = '0;
                            fireMask[c] = 1'b1;
                        end else begin
                            cnt_d[c] = cntInc[W_CNT-1:0];
                        end
                    end
                    ACTIVE: begin
                        if (rel[c]) state_d[c] = IDLE;
                    end
                    default: begin
                        state_d[c] = IDLE;
                        cnt_d[c]   = '0;
                    end
                endcase
            end
            if (fireMask[c]) begin
                for (int e = 0; e < NUM_EVT; e++) begin
                    if (32'(evtIdx_q[c]) == e) events_d[e] = 1'b1;
                end
            end
        end

        if (wrAccess && addrOk) begin
            if (regCtrl) begin
                ctrlEn_d = apb_wdata_i[0];
                if (!apb_wdata_i[0]) begin
                    for (int c = 0; c < NUM_CH; c++) begin
                        state_d[c] = IDLE;
                        cnt_d[c]   = '0;
                    end
                end
            end
            if (regStatus) w1cMask = apb_wdata_i[NUM_CH-1:0];
            if (regIrqEn)  irqEn_d = apb_wdata_i[NUM_CH-1:0];
            for (int c = 0; c < NUM_CH; c++) begin
                if (chValid && (32'(addrCh) == c)) begin
                    case (addrReg)
                        2'd0: begin
                            mode_d[c]   = apb_wdata_i[1:0];
                            debN_d[c]   = apb_wdata_i[4 +: W_CNT];
                            evtIdx_d[c] = apb_wdata_i[15:12];
                            state_d[c]  = IDLE;
                            cnt_d[c]    = '0;
                        end
                        2'd1:    thrHi_d[c] = apb_wdata_i[W_DATA-1:0];
                        2'd2:    thrLo_d[c] = apb_wdata_i[W_DATA-1:0];
                        default: hyst_d[c]  = apb_wdata_i[W_DATA-1:0];
                    endcase
                end
            end
        end

        status_d = (status_q & ~w1cMask) | fireMask;
    end

    // State registers: everything clears asynchronously on reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrlEn_q <= 1'b0;
            status_q <= '0;
            irqEn_q  <= '0;
            events_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c]   <= '0;
                debN_q[c]   <= '0;
                evtIdx_q[c] <= '0;
                thrHi_q[c]  <= '0;
                thrLo_q[c]  <= '0;
                hyst_q[c]   <= '0;
                state_q[c]  <= IDLE;
                cnt_q[c]    <= '0;
            end
        end else begin
            ctrlEn_q <= ctrlEn_d;
            status_q <= status_d;
            irqEn_q  <= irqEn_d;
            events_q <= events_d;
            for (int c = 0; c < NUM_CH; c++) begin
                mode_q[c]   <= mode_d[c];
                debN_q[c]   <= debN_d[c];
                evtIdx_q[c] <= evtIdx_d[c];
                thrHi_q[c]  <= thrHi_d[c];
                thrLo_q[c]  <= thrLo_d[c];
                hyst_q[c]   <= hyst_d[c];
                state_q[c]  <= state_d[c];
                cnt_q[c]    <= cnt_d[c];
            end
        end
    end

endmodule
